// File: rtl/barrel_shift_scheduler.sv
// Two-requester round-robin scheduler feeding one shared 4-bit rotate-right unit.
// Each granted job rotates its word by amt once per pass, cnt passes, then waits for the consumer.
module barrel_shift_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic [1:0] amt0,
    input  logic [1:0] amt1,
    input  logic [2:0] cnt0,
    input  logic [2:0] cnt1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_id,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] work_q, work_d;
    logic [1:0] amt_q, amt_d;
    logic [2:0] passes_q, passes_d;
    logic       id_q, id_d;
    logic       last_id_q, last_id_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;

    logic       win;
    logic [3:0] win_data;
    logic [1:0] win_amt;
    logic [2:0] win_cnt;
    logic [3:0] rot_out;

    // y[i] = w[(i+s) mod 4]: shift a doubled copy right and keep the low nibble.
    function automatic logic [3:0] rotr(input logic [3:0] w, input logic [1:0] s);
        logic [7:0] dbl;
        dbl = {w, w} >> s;
        return dbl[3:0];
    endfunction

    assign rot_out = rotr(work_q, amt_q);

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        amt_d     = amt_q;
        passes_d  = passes_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;

        // Contention goes to whoever did not win last time; a lone request simply wins.
        win      = (req0 && req1) ? ~last_id_q : req1;
        win_data = win ? data1 : data0;
        win_amt  = win ? amt1  : amt0;
        win_cnt  = win ? cnt1  : cnt0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    work_d    = win_data;
                    amt_d     = win_amt;
                    passes_d  = win_cnt;
                    id_d      = win;
                    last_id_d = win;
                    gnt0_d    = ~win;
                    gnt1_d    = win;
                    state_d   = (win_cnt != 3'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d   = rot_out;
                passes_d = passes_q - 3'd1;
                if (passes_q <= 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= 4'd0;
            amt_q     <= 2'd0;
            passes_q  <= 3'd0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            amt_q     <= amt_d;
            passes_q  <= passes_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
        end
    end

    // Handshake: a result transfers on a rising edge where out_valid && out_ready;
    // out_valid/out_data/out_id stay put while out_ready is low.
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = (state_q == DONE) ? work_q : 4'd0;
    assign out_id    = id_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/barrel_shift_scheduler.md
BARREL_SHIFT_SCHEDULER -- requirements
Module: barrel_shift_scheduler

Interface
REQ-001 SHALL have: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: req0, req1  input  1 each  requester 0/1 job request.
REQ-004 SHALL have: data0, data1  input  4 each  word to rotate.
REQ-005 SHALL have: amt0, amt1  input  2 each  rotate-right amount per pass.
REQ-006 SHALL have: cnt0, cnt1  input  3 each  number of passes, 0..7.
REQ-007 SHALL have: gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-008 SHALL have: out_valid  output  1  result available.
REQ-009 SHALL have: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have: out_data  output  4  rotated result.
REQ-011 SHALL have: out_id  output  1  requester index owning out_data.
REQ-012 SHALL have: busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL contain one shared 4-bit rotator: rotr(w,s) = y with y[i] = w[(i+s) mod 4]. Example: rotr(1001,1) = 1100.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE, no req: SHALL remain in IDLE.
REQ-016 IDLE, any req: SHALL select one winner per REQ-017. At the clock edge it SHALL:
- latch the winner's data, amt and cnt;
- set out_id to the winner;
- pulse the winner's gnt for the following cycle only;
- go to SHIFT if cnt != 0, else go to DONE.
REQ-017 Round-robin: pointer last_id, reset 1. If both req, grant !last_id; if one req, grant it. last_id SHALL update to the winner on every grant.
REQ-018 SHIFT: each cycle, work <= rotr(work, amt) and passes <= passes-1. After the pass where passes==1, SHALL go to DONE.
REQ-019 Latency: a grant at edge T gives out_valid in cycle T+cnt+1. The result equals rotr(data, (amt*cnt) mod 4).
REQ-020 DONE: out_valid=1, out_data=work. When out_valid && out_ready at an edge, SHALL return to IDLE and deassert out_valid.
REQ-021 Backpressure: while out_ready=0 in DONE, SHALL hold out_data and out_id stable and issue no grant.
REQ-022 Requesters SHALL hold req/data/amt/cnt stable until gnt, then drop req the cycle after gnt. Req is sampled only in IDLE.
REQ-023 A requester whose req is high in IDLE but loses arbitration SHALL be granted at the next IDLE visit if it still requests.
REQ-024 gnt0 and gnt1 SHALL never be high in the same cycle. At most one job SHALL be in flight.
REQ-025 out_data SHALL be 0 whenever out_valid=0 (not required to be stable outside DONE).

Reset
REQ-026 On rst_n=0, SHALL immediately apply, regardless of clock:
- state=IDLE;
- gnt0=gnt1=0, out_valid=0, out_data=0, out_id=0, busy=0;
- last_id=1, work=0, passes=0.
REQ-027 Reset during SHIFT or DONE SHALL discard the in-flight job with no output. The first edge after rst_n rises SHALL be treated as IDLE.

Verification
REQ-028 Single job: req0, data0=1001, amt0=1, cnt0=1, out_ready=1.
-> gnt0 pulses one cycle; out_valid 2 cycles after the grant edge; out_data=1100, out_id=0.
REQ-029 Multi-pass: req1, data1=1001, amt1=3, cnt1=2.
-> 2 SHIFT cycles, then out_data=0110, out_id=1.
REQ-030 Zero passes: req0, data0=1010, cnt0=0.
-> DONE directly; out_data=1010 one cycle after the grant edge.
REQ-031 Contention: req0 and req1 asserted together from reset and held.
-> first grant gnt0, second gnt1, third gnt0.
-> never both gnt high.
REQ-032 Backpressure: out_ready=0 for 5 cycles in DONE with req1 pending.
-> out_valid, out_data, out_id stable; no gnt.
-> gnt1 follows the accept.
REQ-033 Reset mid-SHIFT: cnt0=7, assert rst_n=0 in the 3rd SHIFT cycle.
-> all outputs 0 asynchronously; no out_valid for that job.
-> a new req1 after reset is granted normally.
